// File: rtl/right_shift_align.sv
// Multi-cycle alignment right shifter for the FP add/sub datapath.
// Shifts a fraction right by up to STEP bits per cycle and collects the dropped bits into a sticky flag.
module right_shift_align #(
  parameter int WIDTH   = 26,
  parameter int SHAMT_W = 8,
  parameter int STEP    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   fraction,
  input  logic [SHAMT_W-1:0] shift_amount,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               sticky,
  output logic [SHAMT_W-1:0] applied_shift
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] eff;
  logic [CNT_W-1:0] step_n;
  logic [WIDTH-1:0] drop_mask;
  logic             accept;

  // Clamp first so the remaining counter can never exceed WIDTH or wrap.
  always_comb begin
    eff = CNT_W'(shift_amount);
    if (32'(shift_amount) >= WIDTH) begin
      eff = CNT_W'(WIDTH);
    end
  end

  always_comb begin
    step_n = remaining;
    if (remaining > CNT_W'(STEP)) begin
      step_n = CNT_W'(STEP);
    end
    drop_mask = ~({WIDTH{1'b1}} << step_n);
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (eff != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (remaining == step_n) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // The working register doubles as the result output; it only has meaning once DONE is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result        <= '0;
      sticky        <= 1'b0;
      remaining     <= '0;
      applied_shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            result        <= fraction;
            sticky        <= 1'b0;
            remaining     <= eff;
            applied_shift <= SHAMT_W'(eff);
          end
        end
        SHIFT: begin
          result    <= result >> step_n;
          sticky    <= sticky | (|(result & drop_mask));
          remaining <= remaining - step_n;
        end
        default: ;
      endcase
    end
  end

endmodule
